// File: rtl/botoes_debouncer_if.sv
// botoes_debouncer_if: button inputs and debounced press outputs of the debouncer
interface botoes_debouncer_if #(
    parameter int N_BOTOES = 8
);
    logic                enable;
    logic [N_BOTOES-1:0] botoes_raw;
    logic [N_BOTOES-1:0] botoes_pulso;
    logic [N_BOTOES-1:0] botoes_estavel;
    logic                algum_pulso;
    modport master (output enable, botoes_raw, input botoes_pulso, botoes_estavel, algum_pulso);
    modport slave (input enable, botoes_raw, output botoes_pulso, botoes_estavel, algum_pulso);
endinterface

// File: rtl/botoes_debouncer.sv
// botoes_debouncer: per-button debounce FSMs producing one clean pulse per press
module botoes_debouncer #(
    parameter int N_BOTOES   = 8,
    parameter int TICK_DIV   = 50000,
    parameter int DEB_TICKS  = 10,
    parameter int ACTIVE_LOW = 1
) (
    input logic clk,
    input logic rst,
    botoes_debouncer_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEB_TICKS);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEB_TICKS - 1);
    typedef enum logic [1:0] {IDLE, DEB_P, HELD, DEB_R} state_t;
    logic [N_BOTOES-1:0] s1;
    logic [N_BOTOES-1:0] sync;
    logic [N_BOTOES-1:0] pulso_n;
    logic [TW-1:0] tcnt;
    logic tick;
    state_t st [N_BOTOES];
    logic [CW-1:0] cnt [N_BOTOES];
    assign tick = tcnt == T_LAST;
    // two-flop synchronizer with polarity folded in, so 1 always means pressed
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1   <= '0;
            sync <= '0;
        end else begin
            s1   <= ACTIVE_LOW != 0 ? ~bus.botoes_raw : bus.botoes_raw;
            sync <= s1;
        end
    // free-running prescaler shared by all buttons
    always_ff @(posedge clk or posedge rst)
        if (rst) tcnt <= '0;
        else tcnt <= tick ? '0 : tcnt + 1'b1;
    // a press is accepted on the tick that completes the DEB_P window
    always_comb begin
        pulso_n = '0;
        for (int i = 0; i < N_BOTOES; i++)
            pulso_n[i] = bus.enable && st[i] == DEB_P && sync[i] && tick && cnt[i] == C_LAST;
    end
    // per-button debounce FSMs; level changes take priority over the tick
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < N_BOTOES; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
            bus.botoes_pulso   <= '0;
            bus.botoes_estavel <= '0;
            bus.algum_pulso    <= 1'b0;
        end else begin
            bus.botoes_pulso <= pulso_n;
            bus.algum_pulso  <= |pulso_n;
            for (int i = 0; i < N_BOTOES; i++) begin
                case (st[i])
                    IDLE: if (sync[i]) begin
                        st[i]  <= DEB_P;
                        cnt[i] <= '0;
                    end
                    DEB_P: if (!sync[i]) begin
                        st[i]  <= IDLE;
                        cnt[i] <= '0;
                    end else if (tick && cnt[i] == C_LAST) begin
                        st[i]                 <= HELD;
                        bus.botoes_estavel[i] <= 1'b1;
                    end else if (tick) cnt[i] <= cnt[i] + 1'b1;
                    HELD: if (!sync[i]) begin
                        st[i]  <= DEB_R;
                        cnt[i] <= '0;
                    end
                    default: if (sync[i]) st[i] <= HELD;
                    else if (tick && cnt[i] == C_LAST) begin
                        st[i]                 <= IDLE;
                        bus.botoes_estavel[i] <= 1'b0;
                    end else if (tick) cnt[i] <= cnt[i] + 1'b1;
                endcase
            end
        end
endmodule

// File: tb/tb_botoes_debouncer.sv
// tb_botoes_debouncer: scoreboard bench for the button debouncer
module tb_botoes_debouncer;
    localparam int N = 8;
    localparam int TDIV = 4;
    localparam int DEB = 3;
    localparam int LAT_LO = 2 + (DEB - 1) * TDIV + 2;
    localparam int LAT_HI = 2 + DEB * TDIV + 1;
    typedef struct {
        logic [7:0] v;
        int lo;
        int hi;
    } exp_t;
    exp_t sb[$];
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    botoes_debouncer_if #(.N_BOTOES(N)) bus();
    botoes_debouncer #(.N_BOTOES(N), .TICK_DIV(TDIV), .DEB_TICKS(DEB), .ACTIVE_LOW(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic expect_pulse(input logic [7:0] v, input int lo, input int hi);
        exp_t e;
        e.v = v;
        e.lo = cyc + lo;
        e.hi = cyc + hi;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.botoes_pulso !== 8'h00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: pulso=%h at cycle %0d, required none", bus.botoes_pulso, cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.botoes_pulso !== e.v) begin
                        errors++;
                        $display("FAIL pulso_value: got %h required %h", bus.botoes_pulso, e.v);
                    end
                    checks++;
                    if (bus.algum_pulso !== 1'b1) begin
                        errors++;
                        $display("FAIL algum_with_pulse: got %b required 1", bus.algum_pulso);
                    end
                    checks++;
                    if ((bus.botoes_estavel & e.v) !== e.v) begin
                        errors++;
                        $display("FAIL estavel_at_pulse: got %h required bits %h set", bus.botoes_estavel, e.v);
                    end
                    checks++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        errors++;
                        $display("FAIL pulse_latency: got cycle %0d required %0d..%0d", cyc, e.lo, e.hi);
                    end
                end
            end else begin
                checks++;
                if (bus.algum_pulso !== 1'b0) begin
                    errors++;
                    $display("FAIL algum_idle: got %b required 0", bus.algum_pulso);
                end
            end
        end
    endtask

    task automatic check_done(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulse(s) missing, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_est(input string name, input logic [7:0] req);
        checks++;
        if (bus.botoes_estavel !== req) begin
            errors++;
            $display("FAIL %s: estavel got %h required %h", name, bus.botoes_estavel, req);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.botoes_pulso !== 8'h00 || bus.botoes_estavel !== 8'h00 || bus.algum_pulso !== 1'b0) begin
            errors++;
            $display("FAIL %s: pulso=%h estavel=%h algum=%b required all 0", name,
                     bus.botoes_pulso, bus.botoes_estavel, bus.algum_pulso);
        end
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.botoes_raw = 8'hFF;
        #1 rst = 1'b1;
        step(3);
        check_zero("reset_state");
        rst = 1'b0;
        step(20);
        check_est("idle_after_reset", 8'h00);
        check_done("idle_after_reset");
    endtask

    task automatic test_clean_press();
        expect_pulse(8'h01, LAT_LO, LAT_HI);
        bus.botoes_raw[0] = 1'b0;
        step(25);
        check_done("clean_press");
        check_est("clean_held", 8'h01);
        bus.botoes_raw[0] = 1'b1;
        step(20);
        check_est("clean_released", 8'h00);
        check_done("clean_release_no_pulse");
    endtask

    task automatic test_bounce();
        int lvl [5] = '{0, 1, 0, 1, 1};
        int len [5] = '{5, 1, 5, 1, 20};
        logic seen = 1'b0;
        for (int p = 0; p < 5; p++) begin
            bus.botoes_raw[3] = lvl[p][0];
            for (int k = 0; k < len[p]; k++) begin
                step(1);
                seen |= bus.botoes_estavel[3];
            end
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL bounce_estavel: got estavel[3]=1 at some cycle, required never");
        end
        check_done("bounce_no_pulse");
    endtask

    task automatic test_release_bounce();
        expect_pulse(8'h20, LAT_LO, LAT_HI);
        bus.botoes_raw[5] = 1'b0;
        step(20);
        check_done("rb_first_press");
        bus.botoes_raw[5] = 1'b1;
        step(3);
        bus.botoes_raw[5] = 1'b0;
        step(20);
        check_est("rb_back_to_held", 8'h20);
        check_done("rb_no_second_pulse");
        bus.botoes_raw[5] = 1'b1;
        step(20);
        check_est("rb_released", 8'h00);
        expect_pulse(8'h20, LAT_LO, LAT_HI);
        bus.botoes_raw[5] = 1'b0;
        step(20);
        check_done("rb_repress");
        bus.botoes_raw[5] = 1'b1;
        step(20);
    endtask

    task automatic test_simultaneous();
        expect_pulse(8'h81, LAT_LO, LAT_HI);
        bus.botoes_raw = 8'h7E;
        step(20);
        check_done("simultaneous");
        check_est("simul_held", 8'h81);
        bus.botoes_raw = 8'hFF;
        step(20);
        check_est("simul_released", 8'h00);
    endtask

    task automatic test_enable();
        bus.enable = 1'b0;
        bus.botoes_raw[2] = 1'b0;
        step(20);
        check_est("enable_silent_held", 8'h04);
        bus.enable = 1'b1;
        step(10);
        check_done("enable_raise_no_pulse");
        bus.botoes_raw[2] = 1'b1;
        step(20);
        expect_pulse(8'h04, LAT_LO, LAT_HI);
        bus.botoes_raw[2] = 1'b0;
        step(20);
        check_done("enable_repress");
        bus.botoes_raw[2] = 1'b1;
        step(20);
    endtask

    task automatic test_reset_mid();
        bus.botoes_raw[1] = 1'b0;
        step(4);
        rst = 1'b1;
        #1 check_zero("rst_in_deb_p");
        #1 rst = 1'b0;
        expect_pulse(8'h02, LAT_LO, LAT_HI);
        step(20);
        check_done("rst_deb_p_repulse");
        check_est("rst_deb_p_held", 8'h02);
        rst = 1'b1;
        #1 check_zero("rst_in_held");
        #1 rst = 1'b0;
        expect_pulse(8'h02, LAT_LO, LAT_HI);
        step(20);
        check_done("rst_held_repulse");
        bus.botoes_raw[1] = 1'b1;
        step(20);
        check_est("rst_final_release", 8'h00);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
